word_byte_sequencer: RTL and testbench
======================================

// Module: word_byte_sequencer
// PURPOSE
//  Sequencer for the 32-bit word splitter datapath. Accepts one word over a
//  valid/ready handshake and issues its bytes one per cycle over a downstream
//  valid/ready handshake, in MSB-first or LSB-first order. Sits between a word
//  producer (register file/ALU result) and a byte-wide sink (UART/display).
// PARAMETERS
//  BYTE_W   8    width of one output byte
//  NBYTES   4    bytes per word; word width = BYTE_W*NBYTES (32)
//  CNT_W    16   width of completed-word counter
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  in_valid   in   1          producer has word on in_word
//  in_ready   out  1          sequencer can accept word this cycle
//  in_word    in   32         word to split (BYTE_W*NBYTES)
//  in_lsb1st  in   1          order, sampled with word: 0=MSB first, 1=LSB first
//  flush      in   1          synchronous abort of word in progress
//  out_valid  out  1          out_byte is valid
//  out_ready  in   1          sink accepts out_byte this cycle
//  out_byte   out  8          current byte
//  out_idx    out  2          beat number within word, 0..NBYTES-1
//  out_last   out  1          current beat is final byte of word
//  busy       out  1          word held (state SEND)
//  word_cnt   out  16         words fully delivered, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset (wins over all): state IDLE; out_valid=0, out_byte=0, out_idx=0,
//    out_last=0, busy=0, word_cnt=0; in_ready=0 while reset high.
//  - States: IDLE (no word held), SEND (word held, emitting beats).
//  - in_ready = !reset & !flush & (IDLE | (out_valid & out_ready & out_last)).
//  - Word accept = in_valid & in_ready at edge: latch in_word and in_lsb1st,
//    beat=0, go/stay SEND. First byte valid the cycle after accept (1-cycle
//    latency). Back-to-back words with out_ready=1: no bubble, NBYTES cycles
//    per word.
//  - Byte select, beat k: MSB-first -> word[(NBYTES-1-k)*BYTE_W +: BYTE_W];
//    LSB-first -> word[k*BYTE_W +: BYTE_W]. out_idx=k; out_last=(k==NBYTES-1).
//  - out_valid=1 exactly in SEND. While out_valid & !out_ready, out_byte,
//    out_idx, out_last held stable; in_word changes ignored.
//  - Beat transfer (out_valid & out_ready): non-last -> beat+1. Last ->
//    word_cnt+1 (wrapping); if new word accepted same edge load it (SEND,
//    beat 0) else IDLE.
//  - flush (priority below reset, above all else): SEND->IDLE next edge,
//    out_valid=0, out_idx=0, out_last=0; word_cnt unchanged even if last beat
//    handshakes same cycle; no word accepted. Flush in IDLE: no effect.
//  - busy = (state==SEND). Outputs registered except in_ready.
//  - Reset mid-word: word discarded, no partial count.
// TESTING
//  1 Reset, in_word=32'hA1B2C3D4, lsb1st=0, out_ready=1 -> bytes A1,B2,C3,D4
//    idx 0..3, out_last on D4 only, word_cnt=1, busy low after.
//  2 Same word, lsb1st=1 -> D4,C3,B2,A1; lsb1st latched, toggling mid-word
//    has no effect.
//  3 Back-to-back 32'h01020304, 32'h05060708, in_valid held, out_ready=1 ->
//    8 consecutive valid beats 01..08 no gap; in_ready high only in idle and
//    last-beat cycle; word_cnt=2.
//  4 out_ready low 3 cycles on beat 1 of 32'hDEADBEEF -> out_byte=AD held
//    stable 3 cycles, then BE,EF; in_ready stays 0 during stall.
//  5 flush during beat 2 of 32'h11223344 -> next cycle out_valid=0, IDLE,
//    word_cnt unchanged; next word 32'h55667788 emits 55 first.
//  6 Preload word_cnt to 16'hFFFF via 65535 words (or force) then one word ->
//    word_cnt=0; reset asserted mid-word -> all outputs 0 next cycle.

Source files
------------

// File: rtl/word_byte_sequencer.sv
// Splits one accepted word into bytes, issued one beat per cycle over a valid/ready
// handshake in MSB-first or LSB-first order, with flush and a completed-word counter.
module word_byte_sequencer #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned WORD_W = BYTE_W * NBYTES,
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_lsb1st,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                lsb1st_q, lsb1st_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xfer, last_xfer, accept;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                    input logic              lsb1st,
                                                    input logic [IDX_W-1:0]  k);
        logic [IDX_W-1:0] sel;
        sel = lsb1st ? k : IDX_W'(NBYTES - 1) - k;
        return word[sel*BYTE_W +: BYTE_W];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = StSend;
        end else if (last_xfer) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        out_valid = (state_q == StSend);
        busy      = (state_q == StSend);
        xfer      = out_valid & out_ready;
        last_xfer = xfer & last_q;
        in_ready  = !reset && !flush && ((state_q == StIdle) || last_xfer);
        accept    = in_valid & in_ready;
    end

    // Beat datapath: the registered byte/index/last always describe the beat on the bus.
    always_comb begin
        word_d   = word_q;
        lsb1st_d = lsb1st_q;
        byte_d   = byte_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (flush) begin
            byte_d = '0;
            idx_d  = '0;
            last_d = 1'b0;
        end else begin
            if (last_xfer) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (accept) begin
                word_d   = in_word;
                lsb1st_d = in_lsb1st;
                idx_d    = '0;
                byte_d   = pick_byte(in_word, in_lsb1st, '0);
                last_d   = (NBYTES == 1);
            end else if (last_xfer) begin
                byte_d = '0;
                idx_d  = '0;
                last_d = 1'b0;
            end else if (xfer) begin
                idx_d  = idx_q + 1'b1;
                byte_d = pick_byte(word_q, lsb1st_q, idx_d);
                last_d = (idx_d == IDX_W'(NBYTES - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            lsb1st_q <= 1'b0;
            byte_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            word_q   <= word_d;
            lsb1st_q <= lsb1st_d;
            byte_q   <= byte_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_byte = byte_q;
    assign out_idx  = idx_q;
    assign out_last = last_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Bench for word_byte_sequencer: directed scenarios plus random traffic, all checked
// against a queue-of-pending-beats model of the sequencer.
module tb_word_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_lsb1st, flush, out_ready;
    logic [31:0] in_word;
    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_byte;
    logic [1:0]  out_idx;
    logic [15:0] word_cnt;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned exp_cnt;
    int          n_vec, n_bad;
    bit          was_reset;

    word_byte_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_lsb1st (in_lsb1st),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !reset && !flush && (exp_q.size() == 0 || (out_ready && exp_q[0].last));
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check_eq("busy", 32'(busy), 32'(exp_q.size() > 0));
        check_eq("word_cnt", 32'(word_cnt), exp_cnt);
        if (exp_q.size() > 0) begin
            check_eq("out_byte", 32'(out_byte), 32'(exp_q[0].b));
            check_eq("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
        end else if (was_reset) begin
            check_eq("rst_byte", 32'(out_byte), 32'h0);
            check_eq("rst_idx", 32'(out_idx), 32'h0);
            check_eq("rst_last", 32'(out_last), 32'h0);
        end
    endtask

    // Inputs are applied at a negedge; this advances the model and DUT by one clock.
    task automatic cycle();
        bit acc;
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(model_ready()));
        acc = in_valid && model_ready();
        was_reset = reset;
        if (reset) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && out_ready) begin
                if (exp_q[0].last) exp_cnt = (exp_cnt + 1) % 65536;
                void'(exp_q.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    beat_t bt;
                    int    sel;
                    sel     = in_lsb1st ? k : 3 - k;
                    bt.b    = in_word[sel*8 +: 8];
                    bt.idx  = 2'(k);
                    bt.last = (k == 3);
                    exp_q.push_back(bt);
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit r, input bit v, input logic [31:0] w, input bit lsb,
                         input bit f, input bit ordy);
        reset     = r;
        in_valid  = v;
        in_word   = w;
        in_lsb1st = lsb;
        flush     = f;
        out_ready = ordy;
        cycle();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_cnt = 0;
        was_reset = 1'b0;
        reset = 1'b1; in_valid = 1'b0; in_word = '0; in_lsb1st = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        drive(1, 1, 32'hFFFF_FFFF, 0, 0, 1);
        drive(1, 0, 32'h0, 0, 0, 0);

        // MSB-first single word
        drive(0, 1, 32'hA1B2C3D4, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0, 0, 1);

        // LSB-first, order toggled mid-word
        drive(0, 1, 32'hA1B2C3D4, 1, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, i[0], 0, 1);

        // Back-to-back words, valid held
        drive(0, 1, 32'h01020304, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 32'h05060708, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0, 0, 1);

        // Stall on beat 1 with a new word waiting
        drive(0, 1, 32'hDEADBEEF, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 32'h12345678, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 32'h0, 0, 0, 1);

        // Flush on beat 2, then a fresh word
        drive(0, 1, 32'h11223344, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 1, 32'h99999999, 0, 1, 1);
        drive(0, 1, 32'h55667788, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0, 0, 1);

        // Flush exactly on the last-beat handshake must not count the word
        drive(0, 1, 32'hCAFEF00D, 1, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 1, 32'h0, 0, 1, 1);
        drive(0, 0, 32'h0, 0, 0, 1);

        // Counter wrap, then reset mid-word
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        drive(0, 1, 32'h0BADF00D, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 32'h0, 0, 0, 1);
        check_eq("cnt_wrapped", 32'(word_cnt), 32'h0);
        drive(0, 1, 32'h76543210, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(1, 1, 32'h0, 0, 0, 1);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_cnt", 32'(word_cnt), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 60), $urandom,
                  1'($urandom), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
